// File: rtl/fetch_decode_pkg.sv
// Shared ISA constants for the fetch/decode stage and the controller:
// opcode encodings, register-field selects and the legal {opcode,op} set.
package fetch_decode_pkg;

  typedef enum logic [2:0] {
    OPC_LDR = 3'b011,
    OPC_STR = 3'b100,
    OPC_ALU = 3'b101,
    OPC_MOV = 3'b110
  } opcode_e;

  localparam logic [2:0] NSEL_RN = 3'd0;
  localparam logic [2:0] NSEL_RD = 3'd1;
  localparam logic [2:0] NSEL_RM = 3'd2;

  localparam int unsigned N_LEGAL = 8;

  localparam logic [4:0] LEGAL_PAIRS [N_LEGAL] = '{
    {OPC_MOV, 2'b10}, {OPC_MOV, 2'b00},
    {OPC_ALU, 2'b00}, {OPC_ALU, 2'b01},
    {OPC_ALU, 2'b10}, {OPC_ALU, 2'b11},
    {OPC_LDR, 2'b00}, {OPC_STR, 2'b00}
  };

  // True when {opc,op} is one of the supported instruction forms.
  function automatic logic is_legal(input logic [2:0] opc, input logic [1:0] op);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < N_LEGAL; i++) begin
      if (LEGAL_PAIRS[i] == {opc, op}) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/fetch_decode_instr_decoder.sv
// Combinational instruction field extraction and sign extension.
module instr_decoder
  import fetch_decode_pkg::*;
(
  input  logic [15:0] ir,
  input  logic [2:0]  nsel,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  regnum,
  output logic [1:0]  shift,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  // Slice fixed fields, sign-extend immediates and mux the register field.
  always_comb begin
    opcode = ir[15:13];
    op     = ir[12:11];
    shift  = ir[4:3];
    sximm8 = {{8{ir[7]}}, ir[7:0]};
    sximm5 = {{11{ir[4]}}, ir[4:0]};
    case (nsel)
      NSEL_RD: regnum = ir[7:5];
      NSEL_RM: regnum = ir[2:0];
      default: regnum = ir[10:8];
    endcase
  end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage: program counter, instruction register, status flags
// and a saturating load counter; decoding is delegated to instr_decoder.
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter int unsigned PC_W = 8,
  parameter int unsigned IR_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     mdata,
  input  logic [PC_W-1:0] c_addr,
  input  logic            loadir,
  input  logic            loadpc,
  input  logic            msel,
  input  logic [2:0]      nsel,
  output logic [PC_W-1:0] mem_addr,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      opcode,
  output logic [1:0]      op,
  output logic [2:0]      regnum,
  output logic [1:0]      shift,
  output logic [15:0]     sximm8,
  output logic [15:0]     sximm5,
  output logic            ir_valid,
  output logic            illegal,
  output logic [15:0]     icount
);

  logic [IR_W-1:0] ir;

  // Memory address mux: datapath C register or program counter.
  always_comb begin
    mem_addr = msel ? c_addr : pc;
  end

  // Program counter, wraps modulo 2^PC_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (loadpc) begin
      pc <= pc + PC_W'(1);
    end
  end

  // Instruction register with valid and sticky illegal-instruction flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir       <= '0;
      ir_valid <= 1'b0;
      illegal  <= 1'b0;
    end else if (loadir) begin
      ir       <= mdata;
      ir_valid <= 1'b1;
      if (!is_legal(mdata[15:13], mdata[12:11])) illegal <= 1'b1;
    end
  end

  // Saturating count of instruction loads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      icount <= '0;
    end else if (loadir && (icount != '1)) begin
      icount <= icount + 16'd1;
    end
  end

  instr_decoder u_dec (
    .ir     (ir),
    .nsel   (nsel),
    .opcode (opcode),
    .op     (op),
    .regnum (regnum),
    .shift  (shift),
    .sximm8 (sximm8),
    .sximm5 (sximm5)
  );

endmodule

// File: tb/tb_fetch_decode.sv
// Scoreboard bench for fetch_decode: expected decode results are queued when
// a load is driven and compared after the capturing edge.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mdata;
  logic [7:0]  c_addr;
  logic        loadir, loadpc, msel;
  logic [2:0]  nsel;
  logic [7:0]  mem_addr, pc;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [2:0]  regnum;
  logic [1:0]  shift;
  logic [15:0] sximm8, sximm5;
  logic        ir_valid, illegal;
  logic [15:0] icount;

  logic [15:0] mem [256];

  always #5 clk = ~clk;

  assign mdata = mem[mem_addr];

  fetch_decode #(.PC_W(8), .IR_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .mdata    (mdata),
    .c_addr   (c_addr),
    .loadir   (loadir),
    .loadpc   (loadpc),
    .msel     (msel),
    .nsel     (nsel),
    .mem_addr (mem_addr),
    .pc       (pc),
    .opcode   (opcode),
    .op       (op),
    .regnum   (regnum),
    .shift    (shift),
    .sximm8   (sximm8),
    .sximm5   (sximm5),
    .ir_valid (ir_valid),
    .illegal  (illegal),
    .icount   (icount)
  );

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [1:0]  shift;
    logic [15:0] sx8;
    logic [15:0] sx5;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  rm;
    logic        ill;
  } exp_t;

  exp_t        sb [$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  exp_pc;
  logic [15:0] exp_cnt;
  logic        exp_ill;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic legal(input logic [4:0] p);
    case (p)
      5'b11010, 5'b11000, 5'b10100, 5'b10101,
      5'b10110, 5'b10111, 5'b01100, 5'b10000: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(input logic [15:0] d, input logic ill_prev);
    exp_t e;
    e.opcode = d[15:13];
    e.op     = d[12:11];
    e.shift  = d[4:3];
    e.sx8    = {{8{d[7]}}, d[7:0]};
    e.sx5    = {{11{d[4]}}, d[4:0]};
    e.rn     = d[10:8];
    e.rd     = d[7:5];
    e.rm     = d[2:0];
    e.ill    = ill_prev | !legal(d[15:11]);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check("opcode",   opcode,   e.opcode);
    check("op",       op,       e.op);
    check("shift",    shift,    e.shift);
    check("sximm8",   sximm8,   e.sx8);
    check("sximm5",   sximm5,   e.sx5);
    check("illegal",  illegal,  e.ill);
    check("ir_valid", ir_valid, 1'b1);
    check("icount",   icount,   exp_cnt);
    check("pc",       pc,       exp_pc);
    for (int n = 0; n < 5; n++) begin
      nsel = n[2:0];
      #1;
      check($sformatf("regnum_n%0d", n), regnum, (n == 1) ? e.rd : (n == 2) ? e.rm : e.rn);
    end
    nsel = 3'd0;
  endtask

  // Drive one instruction load; directed cases supply their own expectation.
  task automatic fetch(input logic lpc, input logic directed, input exp_t de);
    logic [7:0] a;
    exp_t       e;
    a = msel ? c_addr : exp_pc;
    e = directed ? de : model(mem[a], exp_ill);
    sb.push_back(e);
    loadir = 1'b1;
    loadpc = lpc;
    step();
    loadir = 1'b0;
    loadpc = 1'b0;
    exp_ill = e.ill;
    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    if (lpc) exp_pc = exp_pc + 8'd1;
    drain();
  endtask

  task automatic check_reset_state(input string ph);
    check({ph, "_pc"},       pc,       8'h00);
    check({ph, "_icount"},   icount,   16'h0000);
    check({ph, "_ir_valid"}, ir_valid, 1'b0);
    check({ph, "_illegal"},  illegal,  1'b0);
    check({ph, "_opcode"},   opcode,   3'd0);
    check({ph, "_op"},       op,       2'd0);
    check({ph, "_shift"},    shift,    2'd0);
    check({ph, "_sximm8"},   sximm8,   16'h0000);
    check({ph, "_sximm5"},   sximm5,   16'h0000);
    check({ph, "_regnum"},   regnum,   3'd0);
    check({ph, "_mem_addr"}, mem_addr, msel ? c_addr : 8'h00);
  endtask

  // Asynchronous reset pulse between edges while a load/increment is pending.
  task automatic areset();
    @(posedge clk);
    #1;
    loadir = 1'b1;
    loadpc = 1'b1;
    #2 reset = 1'b1;
    #1 check_reset_state("areset");
    #1 reset = 1'b0;
    loadir = 1'b0;
    loadpc = 1'b0;
    sb.delete();
    exp_pc  = 8'h00;
    exp_cnt = 16'h0000;
    exp_ill = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[5] = 16'hD2A5;
    mem[6] = 16'hA0E1;
    mem[7] = 16'hE000;
    mem[8] = 16'h6000;
    reset  = 1'b1;
    loadir = 1'b0;
    loadpc = 1'b0;
    msel   = 1'b0;
    nsel   = 3'd0;
    c_addr = 8'h3C;
    exp_pc  = 8'h00;
    exp_cnt = 16'h0000;
    exp_ill = 1'b0;

    #2 check_reset_state("rst");
    msel = 1'b1;
    #1 check("rst_mem_addr_c", mem_addr, 8'h3C);
    msel = 1'b0;

    // Reset must win over pending load/increment at an edge.
    loadir = 1'b1;
    loadpc = 1'b1;
    step();
    check_reset_state("rst_edge");
    @(negedge clk);
    reset  = 1'b0;
    loadir = 1'b0;

    // PC sweep through wrap.
    for (int i = 1; i <= 256; i++) begin
      step();
      exp_pc = exp_pc + 8'd1;
      check($sformatf("pc_sweep_%0d", i), pc, exp_pc);
    end
    check("pc_wrapped", pc, 8'h00);

    for (int i = 0; i < 5; i++) step();
    loadpc = 1'b0;
    exp_pc = 8'd5;
    check("pc_at_5", pc, 8'h05);

    c_addr = 8'h3C;
    msel = 1'b0;
    #1 check("mem_addr_pc", mem_addr, 8'h05);
    msel = 1'b1;
    #1 check("mem_addr_c", mem_addr, 8'h3C);
    msel = 1'b0;
    #1;

    fetch(1'b1, 1'b1, '{3'd6, 2'd2, 2'd0, 16'hFFA5, 16'h0005, 3'd2, 3'd5, 3'd5, 1'b0});
    fetch(1'b1, 1'b1, '{3'd5, 2'd0, 2'd0, 16'hFFE1, 16'h0001, 3'd0, 3'd7, 3'd1, 1'b0});

    // No load, no increment: everything holds.
    step();
    check("hold_pc", pc, 8'h07);
    check("hold_icount", icount, 16'd2);
    check("hold_opcode", opcode, 3'd5);
    check("hold_regnum", regnum, 3'd0);
    check("hold_illegal", illegal, 1'b0);

    fetch(1'b1, 1'b1, '{3'd7, 2'd0, 2'd0, 16'h0000, 16'h0000, 3'd0, 3'd0, 3'd0, 1'b1});
    fetch(1'b1, 1'b1, '{3'd3, 2'd0, 2'd0, 16'h0000, 16'h0000, 3'd0, 3'd0, 3'd0, 1'b1});

    areset();
    fetch(1'b1, 1'b0, '0);
    for (int i = 0; i < 24; i++) begin
      msel   = 1'($urandom_range(0, 1));
      c_addr = 8'($urandom);
      #1;
      fetch(1'($urandom_range(0, 1)), 1'b0, '0);
    end
    msel = 1'b0;

    // Counter saturation.
    areset();
    loadir = 1'b1;
    for (int i = 1; i <= 70000; i++) begin
      step();
      if (i == 65534) check("icount_fffe", icount, 16'hFFFE);
      if (i == 65535) check("icount_ffff", icount, 16'hFFFF);
    end
    loadir = 1'b0;
    check("icount_sat", icount, 16'hFFFF);
    check("sat_pc", pc, 8'h00);
    check("sat_ir_valid", ir_valid, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
